// File: rtl/sm_run_ctrl.sv
// sm_run_ctrl: run / halt / single-step controller for the sm_cpu core.
// Gates the core clock-enable from host command pulses, stops the core on a
// PC breakpoint or a cycle-count limit, and reports why it stopped together
// with a count of enabled cycles.
module sm_run_ctrl #(
  parameter int PC_WIDTH   = 32,
  parameter int CNT_WIDTH  = 32,
  parameter int STEP_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_run,
  input  logic                  cmd_step,
  input  logic                  cmd_halt,
  input  logic                  cmd_clr,
  input  logic [STEP_WIDTH-1:0] step_count,
  input  logic                  bp_en,
  input  logic [PC_WIDTH-1:0]   bp_addr,
  input  logic [CNT_WIDTH-1:0]  cycle_limit,
  input  logic [PC_WIDTH-1:0]   pc,
  output logic                  cpu_en,
  output logic                  busy,
  output logic                  halted,
  output logic [2:0]            halt_cause,
  output logic [CNT_WIDTH-1:0]  cycle_cnt
);

  typedef enum logic [1:0] {
    HALT = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } state_t;

  localparam logic [2:0] CAUSE_RESET = 3'd0;
  localparam logic [2:0] CAUSE_HOST  = 3'd1;
  localparam logic [2:0] CAUSE_BP    = 3'd2;
  localparam logic [2:0] CAUSE_STEP  = 3'd3;
  localparam logic [2:0] CAUSE_LIMIT = 3'd4;

  localparam logic [STEP_WIDTH-1:0] ONE_STEP = {{(STEP_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0]  ONE_CNT  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0]  ZERO_CNT = '0;

  state_t                state;
  logic [STEP_WIDTH-1:0] stepRem;
  logic [STEP_WIDTH-1:0] stepLoad;
  logic                  bpArmed;
  logic                  bpHit;
  logic                  limHit;
  logic                  stepDone;
  logic                  haltEvt;
  logic [2:0]            nextCause;

  // A step count of zero still executes one instruction.
  assign stepLoad = (step_count == '0) ? ONE_STEP : step_count;

  // The breakpoint is disarmed for the first active cycle so a resume from
  // the breakpoint PC executes that instruction instead of stopping again.
  assign bpHit  = bp_en & bpArmed & (pc == bp_addr);
  assign limHit = (cycle_limit != ZERO_CNT) & (cycle_cnt >= cycle_limit);

  // Mealy enable: a breakpoint or limit hit blocks the instruction in the
  // same cycle it is detected.
  assign cpu_en = busy & ~bpHit & ~limHit;

  assign stepDone = (state == STEP) & (stepRem == ONE_STEP) & cpu_en;

  // Pick the highest-priority halt event of the current active cycle.
  always_comb begin
    haltEvt   = 1'b0;
    nextCause = halt_cause;
    if (busy) begin
      if (bpHit) begin
        haltEvt   = 1'b1;
        nextCause = CAUSE_BP;
      end else if (limHit) begin
        haltEvt   = 1'b1;
        nextCause = CAUSE_LIMIT;
      end else if (cmd_halt) begin
        haltEvt   = 1'b1;
        nextCause = CAUSE_HOST;
      end else if (stepDone) begin
        haltEvt   = 1'b1;
        nextCause = CAUSE_STEP;
      end
    end
  end

  // Run-control state machine with registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= HALT;
      busy       <= 1'b0;
      halted     <= 1'b1;
      halt_cause <= CAUSE_RESET;
      stepRem    <= '0;
      bpArmed    <= 1'b0;
    end else begin
      case (state)
        HALT: begin
          if (cmd_step) begin
            state   <= STEP;
            busy    <= 1'b1;
            halted  <= 1'b0;
            stepRem <= stepLoad;
            bpArmed <= 1'b0;
          end else if (cmd_run) begin
            state   <= RUN;
            busy    <= 1'b1;
            halted  <= 1'b0;
            bpArmed <= 1'b0;
          end
        end
        RUN, STEP: begin
          bpArmed <= 1'b1;
          if ((state == STEP) && cpu_en) begin
            stepRem <= stepRem - ONE_STEP;
          end
          if (haltEvt) begin
            state      <= HALT;
            busy       <= 1'b0;
            halted     <= 1'b1;
            halt_cause <= nextCause;
          end
        end
        default: begin
          state  <= HALT;
          busy   <= 1'b0;
          halted <= 1'b1;
        end
      endcase
    end
  end

  // Enabled-cycle counter: saturates at all-ones, host clear has priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
    end else if (cmd_clr) begin
      cycle_cnt <= '0;
    end else if (cpu_en && !(&cycle_cnt)) begin
      cycle_cnt <= cycle_cnt + ONE_CNT;
    end
  end

endmodule

// File: tb/tb_sm_run_ctrl.sv
// Self-checking bench for sm_run_ctrl: expected results are queued when the
// stimulus is issued and compared in order when the controller responds.
module tb_sm_run_ctrl;

  localparam int PCW = 32;
  localparam int CW  = 32;
  localparam int SW  = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           cmd_run, cmd_step, cmd_halt, cmd_clr;
  logic [SW-1:0]  step_count;
  logic           bp_en;
  logic [PCW-1:0] bp_addr;
  logic [CW-1:0]  cycle_limit;
  logic [PCW-1:0] pc;
  logic           cpu_en, busy, halted;
  logic [2:0]     halt_cause;
  logic [CW-1:0]  cycle_cnt;

  // Core stand-in: PC advances by one on every enabled cycle.
  logic [PCW-1:0] pcModel;
  logic [PCW-1:0] pcLoadVal;
  logic           pcLoad;

  typedef struct {
    string       name;
    logic [31:0] value;
  } exp_t;

  typedef struct {
    logic       alsoRun;
    int         stepCount;
    int         expEn;
    logic [2:0] expCause;
  } stepVec_t;

  exp_t     sbQ[$];
  stepVec_t stepTab[6];
  int       checks = 0;
  int       errors = 0;

  always #5 clk = ~clk;

  assign pc = pcModel;

  // Core PC model driven by the controller's clock-enable.
  always @(posedge clk) begin
    if (pcLoad) pcModel <= pcLoadVal;
    else if (cpu_en) pcModel <= pcModel + 1;
  end

  sm_run_ctrl #(.PC_WIDTH(PCW), .CNT_WIDTH(CW), .STEP_WIDTH(SW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_run(cmd_run), .cmd_step(cmd_step), .cmd_halt(cmd_halt), .cmd_clr(cmd_clr),
    .step_count(step_count), .bp_en(bp_en), .bp_addr(bp_addr),
    .cycle_limit(cycle_limit), .pc(pc),
    .cpu_en(cpu_en), .busy(busy), .halted(halted),
    .halt_cause(halt_cause), .cycle_cnt(cycle_cnt)
  );

  task automatic expectVal(input string name, input logic [31:0] v);
    exp_t e;
    e.name  = name;
    e.value = v;
    sbQ.push_back(e);
  endtask

  task automatic checkOutput(input logic [31:0] actual);
    exp_t e;
    checks++;
    if (sbQ.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_empty actual=%0d", actual);
    end else begin
      e = sbQ.pop_front();
      if (actual !== e.value) begin
        errors++;
        $display("[TB] FAIL %s actual=%0d required=%0d", e.name, actual, e.value);
      end
    end
  endtask

  // One-cycle command pulse; returns at the falling edge of the first
  // cycle after the command was accepted.
  task automatic applyStimulus(input logic run, input logic step,
                               input logic halt, input logic clr);
    @(negedge clk);
    cmd_run  = run;
    cmd_step = step;
    cmd_halt = halt;
    cmd_clr  = clr;
    @(negedge clk);
    cmd_run  = 1'b0;
    cmd_step = 1'b0;
    cmd_halt = 1'b0;
    cmd_clr  = 1'b0;
  endtask

  // Counts enabled cycles until the controller halts, with a cycle budget.
  task automatic measureRun(output int enCount);
    int n;
    enCount = 0;
    n = 0;
    while (!halted && n < 2000) begin
      if (cpu_en) enCount++;
      @(negedge clk);
      n++;
    end
    if (!halted) begin
      checks++;
      errors++;
      $display("[TB] FAIL run_timeout actual=busy required=halted");
    end
  endtask

  task automatic loadPc(input logic [PCW-1:0] v);
    @(negedge clk);
    pcLoad    = 1'b1;
    pcLoadVal = v;
    @(negedge clk);
    pcLoad = 1'b0;
  endtask

  // Main sequence: reset, step table, breakpoint, priority, limit, host halt,
  // reset during a run.
  initial begin
    int en;
    int n;

    rst_n = 1'b0;
    cmd_run = 1'b0; cmd_step = 1'b0; cmd_halt = 1'b0; cmd_clr = 1'b0;
    step_count = '0; bp_en = 1'b0; bp_addr = '0; cycle_limit = '0;
    pcLoad = 1'b1; pcLoadVal = '0;

    stepTab[0] = '{1'b0, 3,   3,   3'd3};
    stepTab[1] = '{1'b0, 0,   1,   3'd3};
    stepTab[2] = '{1'b0, 1,   1,   3'd3};
    stepTab[3] = '{1'b0, 7,   7,   3'd3};
    stepTab[4] = '{1'b1, 2,   2,   3'd3};
    stepTab[5] = '{1'b0, 255, 255, 3'd3};

    repeat (4) @(negedge clk);
    expectVal("rst_status", 32'h08);
    checkOutput(32'({cpu_en, busy, halted, halt_cause}));
    expectVal("rst_cnt", 32'd0);
    checkOutput(cycle_cnt);
    rst_n  = 1'b1;
    pcLoad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      expectVal("idle_status", 32'h08);
      checkOutput(32'({cpu_en, busy, halted, halt_cause}));
      expectVal("idle_cnt", 32'd0);
      checkOutput(cycle_cnt);
    end

    $display("[TB] step table");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      step_count = SW'(stepTab[i].stepCount);
      expectVal($sformatf("step%0d_en", i), 32'(stepTab[i].expEn));
      expectVal($sformatf("step%0d_cause", i), 32'(stepTab[i].expCause));
      expectVal($sformatf("step%0d_cnt", i), 32'(stepTab[i].expEn));
      applyStimulus(stepTab[i].alsoRun, 1'b1, 1'b0, 1'b0);
      measureRun(en);
      checkOutput(32'(en));
      checkOutput(32'(halt_cause));
      checkOutput(cycle_cnt);
    end

    $display("[TB] breakpoint");
    loadPc('0);
    bp_en   = 1'b1;
    bp_addr = 32'd5;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    en = 0;
    n  = 0;
    while (!halted && n < 50) begin
      if (pc == 32'd5) begin
        expectVal("bp_cpu_en_at_bp", 32'd0);
        checkOutput(32'(cpu_en));
      end
      if (cpu_en) en++;
      @(negedge clk);
      n++;
    end
    expectVal("bp_en_cycles", 32'd5);
    checkOutput(32'(en));
    expectVal("bp_cause", 32'd2);
    checkOutput(32'(halt_cause));
    expectVal("bp_pc", 32'd5);
    checkOutput(pc);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    expectVal("bp_resume_en", 32'd1);
    checkOutput(32'(cpu_en));
    @(negedge clk);
    expectVal("bp_resume_pc", 32'd6);
    checkOutput(pc);
    cmd_halt = 1'b1;
    @(negedge clk);
    cmd_halt = 1'b0;
    expectVal("bp_resume_halted", 32'd1);
    checkOutput(32'(halted));
    expectVal("bp_resume_pc_end", 32'd7);
    checkOutput(pc);

    $display("[TB] halt vs breakpoint priority");
    loadPc('0);
    bp_addr = 32'd3;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    expectVal("pri_pc", 32'd3);
    checkOutput(pc);
    cmd_halt = 1'b1;
    expectVal("pri_cpu_en", 32'd0);
    checkOutput(32'(cpu_en));
    @(negedge clk);
    cmd_halt = 1'b0;
    expectVal("pri_halted", 32'd1);
    checkOutput(32'(halted));
    expectVal("pri_cause", 32'd2);
    checkOutput(32'(halt_cause));
    expectVal("pri_cnt", 32'd3);
    checkOutput(cycle_cnt);
    bp_en = 1'b0;

    $display("[TB] cycle limit");
    cycle_limit = 32'd120;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    expectVal("lim_en", 32'd120);
    expectVal("lim_cause", 32'd4);
    expectVal("lim_cnt", 32'd120);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    measureRun(en);
    checkOutput(32'(en));
    checkOutput(32'(halt_cause));
    checkOutput(cycle_cnt);
    expectVal("lim_again_en", 32'd0);
    expectVal("lim_again_cnt", 32'd120);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    measureRun(en);
    checkOutput(32'(en));
    checkOutput(cycle_cnt);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    expectVal("lim_clr_en", 32'd120);
    expectVal("lim_clr_cnt", 32'd120);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    measureRun(en);
    checkOutput(32'(en));
    checkOutput(cycle_cnt);
    cycle_limit = '0;

    $display("[TB] host halt");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    cmd_halt = 1'b1;
    expectVal("host_cpu_en_k", 32'd1);
    checkOutput(32'(cpu_en));
    @(negedge clk);
    cmd_halt = 1'b0;
    expectVal("host_cpu_en_k1", 32'd0);
    checkOutput(32'(cpu_en));
    expectVal("host_cause", 32'd1);
    checkOutput(32'(halt_cause));
    expectVal("host_cnt", 32'd11);
    checkOutput(cycle_cnt);

    $display("[TB] reset during run");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (cycle_cnt != 32'd40 && n < 200) begin
      @(negedge clk);
      n++;
    end
    expectVal("midrst_cnt_before", 32'd40);
    checkOutput(cycle_cnt);
    rst_n = 1'b0;
    @(negedge clk);
    expectVal("midrst_status", 32'h08);
    checkOutput(32'({cpu_en, busy, halted, halt_cause}));
    expectVal("midrst_cnt", 32'd0);
    checkOutput(cycle_cnt);
    rst_n = 1'b1;
    @(negedge clk);

    if (sbQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_leftover actual=%0d required=0", sbQ.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
